// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter.
// Snoops CPU data-port writes: a write to TX_ADDR queues wr_data[7:0] in a
// small byte FIFO, a write to STAT_ADDR clears the sticky overflow flag.
// Queued bytes are serialised LSB first (start, 8 data, stop) on tx.
module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] TX_ADDR      = 16'hFFFF,
    parameter logic [15:0] STAT_ADDR    = 16'hFFFE
) (
    input  logic        CLK_50MHZ,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        fifo_empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;

    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic push_req;
    logic push;
    logic pop;
    logic stat_wr;
    logic baud_done;
    logic unused_hi;

    assign push_req  = wr_en && (addr == TX_ADDR);
    assign push      = push_req && !full_q;
    assign pop       = (state_q == S_IDLE) && !empty_q;
    assign stat_wr   = wr_en && (addr == STAT_ADDR);
    assign baud_done = (baud_q == BAUD_LAST);
    // Upper write-data byte is never transmitted.
    assign unused_hi = ^wr_data[15:8];

    // FIFO pointers, occupancy flags and the sticky overflow flag.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        ovf_d    = ovf_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // A full-FIFO write is dropped even if a pop frees a slot this edge.
        if (push_req && full_q) begin
            ovf_d = 1'b1;
        end else if (stat_wr) begin
            ovf_d = 1'b0;
        end
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    // Transmit FSM: next state, baud/bit counters and the next tx level.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty_q) begin
                    shift_d = fifo_mem[rd_ptr_q];
                    baud_d  = '0;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (baud_done) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State register; reset aborts any frame and discards queued bytes.
    always_ff @(posedge CLK_50MHZ) begin
        if (reset) begin
            state_q   <= S_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage write; contents are don't-care until pointed at.
    always_ff @(posedge CLK_50MHZ) begin
        if (push && !reset) begin
            fifo_mem[wr_ptr_q] <= wr_data[7:0];
        end
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE);
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign rd_data    = (addr == STAT_ADDR) ? {12'b0, ovf_q, busy, full_q, empty_q}
                                            : 16'h0000;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A negedge line monitor captures each frame as 40 tx samples (bit n of the
// vector is the sample n cycles after the start edge) for comparison.
module tb_mmio_uart_tx;

    localparam logic [15:0] TX_ADDR   = 16'hFFFF;
    localparam logic [15:0] STAT_ADDR = 16'hFFFE;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [15:0] addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic        fifo_empty;

    int n_checks = 0;
    int n_fail   = 0;

    logic [39:0] rx_q [$];
    int          full_cnt = 0;

    mmio_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH  (4),
        .TX_ADDR     (TX_ADDR),
        .STAT_ADDR   (STAT_ADDR)
    ) dut (
        .CLK_50MHZ (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .tx        (tx),
        .busy      (busy),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line monitor: records each frame, aborts a partial frame on reset.
    initial begin
        logic [39:0] vec;
        int          n;
        bit          active;
        vec = '1;
        n = 0;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_full === 1'b1) full_cnt++;
            if (reset !== 1'b0) begin
                active = 1'b0;
                n = 0;
            end else if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    vec = '1;
                    vec[0] = tx;
                    n = 1;
                end
            end else begin
                vec[n] = tx;
                n++;
                if (n == 40) begin
                    rx_q.push_back(vec);
                    active = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write on the next edge, bus released afterwards.
    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        wr_en   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        addr    = 16'h0000;
        wr_data = 16'h0000;
    endtask

    function automatic logic [39:0] exp_frame(input logic [7:0] b);
        logic [39:0] v;
        v = '1;
        for (int i = 0; i < 4; i++) v[i] = 1'b0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 4; j++) v[4 + 4 * i + j] = b[i];
        return v;
    endfunction

    task automatic wait_frames(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (rx_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        check(tag, 64'(rx_q.size()), 64'(n));
    endtask

    task automatic next_frame(input string tag, input logic [39:0] exp);
        logic [39:0] v;
        v = '0;
        if (rx_q.size() > 0) v = rx_q.pop_front();
        check(tag, 64'(v), 64'(exp));
    endtask

    task automatic read_stat(input string tag, input logic [15:0] exp);
        addr = STAT_ADDR;
        #1;
        check(tag, 64'(rd_data), 64'(exp));
        addr = 16'h0000;
    endtask

    initial begin
        logic [7:0] ovf_bytes  [6];
        logic [7:0] wrap_bytes [10];
        int         full_before;
        ovf_bytes  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        wrap_bytes = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h7E,
                       8'hC3, 8'h5A, 8'h96, 8'h0F, 8'hE1};

        // Reset state
        reset   = 1'b1;
        wr_en   = 1'b0;
        addr    = 16'h0000;
        wr_data = 16'h0000;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_empty", 64'(fifo_empty), 64'd1);
        check("rst_full", 64'(fifo_full), 64'd0);
        read_stat("rst_stat", 16'h0001);
        addr = TX_ADDR;
        #1;
        check("rd_other_addr", 64'(rd_data), 64'd0);
        addr = 16'h0000;

        // Single byte 0x55 with upper byte 0x12 ignored
        bus_write(TX_ADDR, 16'h1255);
        check("sb_tx_after_push", 64'(tx), 64'd1);
        check("sb_empty_after_push", 64'(fifo_empty), 64'd0);
        tick();
        check("sb_start_tx", 64'(tx), 64'd0);
        check("sb_start_busy", 64'(busy), 64'd1);
        check("sb_empty_after_pop", 64'(fifo_empty), 64'd1);
        repeat (40) tick();
        check("sb_end_busy", 64'(busy), 64'd0);
        check("sb_end_tx", 64'(tx), 64'd1);
        check("sb_frames", 64'(rx_q.size()), 64'd1);
        next_frame("sb_frame_55", 40'hF0F0F0F0F0);

        // Back-to-back frames A5, 3C
        tick();
        bus_write(TX_ADDR, 16'h00A5);
        bus_write(TX_ADDR, 16'h003C);
        check("b2b_first_start", 64'(tx), 64'd0);
        repeat (40) tick();
        check("b2b_gap_tx", 64'(tx), 64'd1);
        check("b2b_gap_busy", 64'(busy), 64'd0);
        tick();
        check("b2b_second_start", 64'(tx), 64'd0);
        check("b2b_empty", 64'(fifo_empty), 64'd1);
        wait_frames(2, 100, "b2b_frames");
        next_frame("b2b_frame_a5", 40'hFF0F00F0F0);
        next_frame("b2b_frame_3c", exp_frame(8'h3C));

        // Overflow: six pushes on consecutive edges into depth-4 FIFO
        repeat (3) tick();
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            addr    = TX_ADDR;
            wr_data = {8'hEE, ovf_bytes[i]};
            tick();
            if (i == 1) check("ovf_popped_busy", 64'(busy), 64'd1);
            if (i == 4) check("ovf_full_at_4", 64'(fifo_full), 64'd1);
        end
        wr_en = 1'b0;
        read_stat("ovf_stat", 16'h000E);
        wait_frames(5, 5 * 41 + 20, "ovf_frames");
        for (int i = 0; i < 5; i++)
            next_frame($sformatf("ovf_frame_%0d", i + 1), exp_frame(ovf_bytes[i]));
        repeat (60) tick();
        check("ovf_byte6_dropped", 64'(rx_q.size()), 64'd0);
        read_stat("ovf_stat_idle", 16'h0009);
        bus_write(STAT_ADDR, 16'hFFFF);
        read_stat("ovf_cleared", 16'h0001);

        // Pointer wrap: ten single pushes, each after the previous frame
        full_before = full_cnt;
        for (int i = 0; i < 10; i++) begin
            bus_write(TX_ADDR, {8'h00, wrap_bytes[i]});
            wait_frames(1, 60, $sformatf("wrap_arrive_%0d", i));
            next_frame($sformatf("wrap_frame_%0d", i), exp_frame(wrap_bytes[i]));
        end
        check("wrap_never_full", 64'(full_cnt - full_before), 64'd0);

        // Reset during DATA bit 3 with two bytes still queued
        tick();
        bus_write(TX_ADDR, 16'h00C7);
        bus_write(TX_ADDR, 16'h0018);
        bus_write(TX_ADDR, 16'h0029);
        repeat (16) tick();
        check("rmf_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rmf_tx", 64'(tx), 64'd1);
        check("rmf_busy", 64'(busy), 64'd0);
        check("rmf_empty", 64'(fifo_empty), 64'd1);
        read_stat("rmf_stat", 16'h0001);
        repeat (100) tick();
        check("rmf_nothing_sent", 64'(rx_q.size()), 64'd0);
        bus_write(TX_ADDR, 16'h0042);
        wait_frames(1, 60, "rmf_new_arrive");
        next_frame("rmf_new_frame", exp_frame(8'h42));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
